// File: rtl/booth_multi_seq.sv
// Iterative radix-4 Booth multiplier: one partial product retired per clock,
// start/done handshake, per-operation signed/unsigned mode.
module booth_multi_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned N_ITER = WIDTH / 2 + 1;
   localparam int unsigned QW     = WIDTH + 2;
   localparam int unsigned AW     = WIDTH + 3;
   localparam int unsigned SW     = AW + QW + 1;
   localparam int unsigned CW     = $clog2(N_ITER + 1);
   localparam int unsigned PW     = 2 * WIDTH;

   // S_CAPT registers the product so done/result appear one cycle after the last iteration
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_CAPT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   acc_q, acc_d;
   logic [QW-1:0]   q_q, q_d;
   logic            qm1_q, qm1_d;
   logic [QW-1:0]   m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [PW-1:0]   result_q, result_d;

   logic [QW-1:0]   a_ext_c;
   logic [QW-1:0]   b_ext_c;
   logic [AW-1:0]   m_sx_c;
   logic [AW-1:0]   m_x2_c;
   logic [AW-1:0]   pp_c;
   logic [AW-1:0]   sum_c;
   logic [SW-1:0]   shift_c;
   logic [PW-1:0]   prod_c;

   // Operand extension; two extra bits let unsigned operands recode in N_ITER steps
   always_comb begin
      a_ext_c = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
      b_ext_c = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
   end

   // Booth recode of {q[1], q[0], q_m1}, accumulate, then arithmetic shift by two
   always_comb begin
      m_sx_c = {m_q[QW-1], m_q};
      m_x2_c = {m_q, 1'b0};
      pp_c   = '0;
      case ({q_q[1:0], qm1_q})
         3'b001, 3'b010: pp_c = m_sx_c;
         3'b011:         pp_c = m_x2_c;
         3'b100:         pp_c = AW'(0) - m_x2_c;
         3'b101, 3'b110: pp_c = AW'(0) - m_sx_c;
         default:        pp_c = '0;
      endcase
      sum_c   = acc_q + pp_c;
      shift_c = SW'($signed({sum_c, q_q, qm1_q}) >>> 2);
      prod_c  = {acc_q[WIDTH-3:0], q_q};
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      q_d      = q_q;
      qm1_d    = qm1_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = a_ext_c;
               q_d     = b_ext_c;
               qm1_d   = 1'b0;
               acc_d   = '0;
               cnt_d   = CW'(N_ITER - 1);
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = shift_c[SW-1 -: AW];
            q_d   = shift_c[QW:1];
            qm1_d = shift_c[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_CAPT;
            end
         end
         S_CAPT: begin
            result_d = prod_c;
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         q_q      <= '0;
         qm1_q    <= 1'b0;
         m_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         qm1_q    <= qm1_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_booth_multi_seq.sv
// Scoreboard bench for booth_multi_seq at WIDTH = 8, 16 and 32 running side by side.
module tb_booth_multi_seq;

   logic clk = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_fin   = 0;
   int   cyc     = 0;

   localparam int unsigned RND = 400;

   always #5 clk = ~clk;

   // Free-running cycle count used to measure start-to-done latency
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_w
      localparam int unsigned W   = 8 << gi;
      localparam int unsigned PW  = 2 * W;
      localparam int unsigned LAT = W / 2 + 2;

      typedef struct {
         logic [PW-1:0] prod;
         int            cyc;
      } exp_t;

      logic          rst   = 1'b1;
      logic          start = 1'b0;
      logic          smode = 1'b0;
      logic [W-1:0]  a     = '0;
      logic [W-1:0]  b     = '0;
      logic          busy;
      logic          done;
      logic [PW-1:0] result;
      logic [PW-1:0] hold_val = '0;
      exp_t          sb[$];
      exp_t          mon_e;

      booth_multi_seq #(.WIDTH(W)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .start       (start),
         .signed_mode (smode),
         .a           (a),
         .b           (b),
         .busy        (busy),
         .done        (done),
         .result      (result)
      );

      // Reference product from plain 64-bit arithmetic
      function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
         logic signed [63:0] sx, sy;
         logic [63:0]        ux, uy, p;
         sx = 64'($signed(x));
         sy = 64'($signed(y));
         ux = 64'(x);
         uy = 64'(y);
         if (s) p = 64'(sx * sy);
         else   p = ux * uy;
         return PW'(p);
      endfunction

      function automatic logic [W-1:0] pick();
         logic [W-1:0] v;
         case ($urandom_range(7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
         endcase
         return v;
      endfunction

      // Waits (bounded) for busy to drop, optionally disturbing inputs while busy
      task automatic wait_idle(input bit disturb);
         int k;
         k = 0;
         while (busy && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (busy && disturb) begin
               start = 1'($urandom_range(1));
               a     = W'($urandom);
               b     = W'($urandom);
               smode = 1'($urandom_range(1));
            end
         end
         start = 1'b0;
         if (busy) chk($sformatf("w%0d busy timeout", W), 64'(busy), 64'(0));
      endtask

      task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input bit disturb);
         exp_t e;
         a     = x;
         b     = y;
         smode = s;
         start = 1'b1;
         @(posedge clk);
         #1;
         e.prod = ref_mul(x, y, s);
         e.cyc  = cyc;
         sb.push_back(e);
         chk($sformatf("w%0d busy after start", W), 64'(busy), 64'(1));
         start = 1'b0;
         wait_idle(disturb);
      endtask

      task automatic reset_check(input string tag);
         @(posedge clk);
         #1;
         sb.delete();
         chk($sformatf("w%0d %s busy", W, tag), 64'(busy), 64'(0));
         chk($sformatf("w%0d %s done", W, tag), 64'(done), 64'(0));
         chk($sformatf("w%0d %s result", W, tag), 64'(result), 64'(0));
         hold_val = '0;
      endtask

      // Driver
      initial begin
         exp_t e;
         @(posedge clk);
         reset_check("por");
         rst = 1'b0;

         do_op('1, '1, 1'b1, 1'b0);
         do_op({1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b1, 1'b0);
         do_op(W'(-7), W'(3), 1'b1, 1'b0);
         do_op('1, '1, 1'b0, 1'b0);
         do_op({1'b1, {(W-1){1'b0}}}, {1'b0, {(W-1){1'b1}}}, 1'b1, 1'b0);
         do_op({1'b1, {(W-1){1'b0}}}, {1'b0, {(W-1){1'b1}}}, 1'b0, 1'b0);
         do_op('0, '1, 1'b1, 1'b0);

         // 5 x 6 with a 9 x 9 start pulse and toggling operands while busy
         a = W'(5); b = W'(6); smode = 1'b0; start = 1'b1;
         @(posedge clk);
         #1;
         e.prod = PW'(30);
         e.cyc  = cyc;
         sb.push_back(e);
         a = W'(9); b = W'(9); start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         a = ~a;
         wait_idle(1'b1);

         for (int i = 0; i < int'(2 * RND); i++) begin
            do_op(pick(), pick(), 1'(i & 1), (i % 3) == 0);
         end

         // Reset in the middle of RUN discards the operation
         a = pick(); b = pick(); smode = 1'b1; start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b1;
         reset_check("mid-run rst");
         rst = 1'b0;
         repeat (LAT + 4) @(posedge clk);
         #1;

         // Reset and start together: reset wins
         a = W'(3); b = W'(3); start = 1'b1; rst = 1'b1;
         reset_check("rst+start");
         start = 1'b0;
         rst   = 1'b0;
         repeat (LAT + 4) @(posedge clk);
         #1;
         chk($sformatf("w%0d pending after resets", W), 64'(sb.size()), 64'(0));

         do_op(W'(-7), W'(3), 1'b1, 1'b1);
         chk($sformatf("w%0d pending at end", W), 64'(sb.size()), 64'(0));
         n_fin++;
      end

      // Monitor: pops the scoreboard on every done pulse, otherwise checks result holds
      always @(negedge clk) begin
         if (!rst) begin
            if (done) begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL w%0d spurious done: result 0x%0h with no operation pending", W, result);
               end else begin
                  mon_e = sb.pop_front();
                  chk($sformatf("w%0d product", W), 64'(result), 64'(mon_e.prod));
                  chk($sformatf("w%0d latency", W), 64'(cyc - mon_e.cyc), 64'(LAT));
                  chk($sformatf("w%0d busy with done", W), 64'(busy), 64'(1));
                  hold_val = mon_e.prod;
               end
            end else begin
               chk($sformatf("w%0d result hold", W), 64'(result), 64'(hold_val));
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 80000 && n_fin < 3; k++) @(posedge clk);
      if (n_fin < 3) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: %0d of 3 drivers finished", n_fin);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
